// File: rtl/cv32e40s_pkg.sv
// Shared PMA types for the cv32e40s memory interface: region descriptor,
// default attributes and the PMA filter state encoding.
package cv32e40s_pkg;

  // Word-granular region: word_addr_low inclusive, word_addr_high exclusive.
  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
  } pma_cfg_t;

  // Attributes for addresses that miss every configured region.
  localparam pma_cfg_t PMA_R_DEFAULT = '{
    word_addr_low:  32'h0,
    word_addr_high: 32'h0,
    main:           1'b0,
    bufferable:     1'b0,
    cacheable:      1'b0
  };

  // Attributes used everywhere when no regions are configured.
  localparam pma_cfg_t NO_PMA_R_DEFAULT = '{
    word_addr_low:  32'h0,
    word_addr_high: 32'h0,
    main:           1'b1,
    bufferable:     1'b0,
    cacheable:      1'b0
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    ERR_RESP
  } pma_filter_state_e;

endpackage

// File: rtl/cv32e40s_pma_lookup.sv
// Combinational PMA region lookup: lowest matching region index wins and
// the access is flagged blocked when a fetch or misaligned access hits I/O.
module cv32e40s_pma_lookup
  import cv32e40s_pkg::*;
#(
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG [(PMA_NUM_REGIONS > 0 ? PMA_NUM_REGIONS : 1)-1:0] =
    '{default: PMA_R_DEFAULT}
) (
  input  logic [31:0] addr,
  input  logic        fetch,
  input  logic        misaligned,
  output pma_cfg_t    pma_attr,
  output logic        blocked
);

  logic [31:0] word_addr;
  logic [1:0]  unused_addr_lsb;

  assign word_addr       = {2'b00, addr[31:2]};
  assign unused_addr_lsb = addr[1:0];

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    pma_attr = PMA_R_DEFAULT;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
      if ((word_addr >= PMA_CFG[i].word_addr_low) &&
          (word_addr <  PMA_CFG[i].word_addr_high)) begin
        pma_attr = PMA_CFG[i];
      end
    end
    if (PMA_NUM_REGIONS == 0) begin
      pma_attr = NO_PMA_R_DEFAULT;
    end
  end

  assign blocked = (fetch || misaligned) && !pma_attr.main;

endmodule

// File: rtl/cv32e40s_pma_filter.sv
// PMA enforcement stage between the core OBI port and the bus. Blocked
// requests get an in-order local error response once the bus drains.
// Optional saturating PMA error counter: define CV32E40S_PMA_ERR_CNT_EN.
module cv32e40s_pma_filter
  import cv32e40s_pkg::*;
#(
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG [(PMA_NUM_REGIONS > 0 ? PMA_NUM_REGIONS : 1)-1:0] =
    '{default: PMA_R_DEFAULT},
  parameter bit       IS_INSTR_SIDE   = 1'b0,
  parameter int       MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic        core_misaligned_i,
  output logic        core_rvalid_o,
  output logic        core_err_o,
  output logic        core_pma_err_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic        bus_bufferable_o,
  output logic        bus_cacheable_o,
  input  logic        bus_rvalid_i,
  input  logic        bus_err_i,
  output logic [15:0] pma_err_cnt_o,
  input  logic        pma_err_cnt_clr_i
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  pma_filter_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt, cnt_next;
  pma_cfg_t          attr;
  logic              blocked;
  logic              cnt_room;
  logic              bus_xfer;
  logic              bus_rsp;
  logic [63:0]       unused_attr_range;

  cv32e40s_pma_lookup #(
    .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
    .PMA_CFG         (PMA_CFG)
  ) u_lookup (
    .addr       (core_addr_i),
    .fetch      (IS_INSTR_SIDE),
    .misaligned (core_misaligned_i),
    .pma_attr   (attr),
    .blocked    (blocked)
  );

  assign unused_attr_range = {attr.word_addr_low, attr.word_addr_high};

  assign bus_addr_o       = core_addr_i;
  assign bus_we_o         = core_we_i;
  assign bus_bufferable_o = attr.bufferable && core_we_i && !IS_INSTR_SIDE;
  assign bus_cacheable_o  = attr.cacheable;

  // Counter events are derived independently of bus_req_o to keep the
  // next-state logic free of combinational feedback.
  assign cnt_room = (cnt < CNT_MAX);
  assign bus_xfer = (state_q == IDLE) && core_req_i && !blocked && cnt_room && bus_gnt_i;
  assign bus_rsp  = bus_rvalid_i && (cnt != '0);

  always_comb begin
    unique case ({bus_xfer, bus_rsp})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bus_req_o      = 1'b0;
    core_gnt_o     = 1'b0;
    core_rvalid_o  = bus_rvalid_i;
    core_err_o     = bus_err_i;
    core_pma_err_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_req_i && blocked) begin
          core_gnt_o = 1'b1;
          state_d    = (cnt_next == '0) ? ERR_RESP : WAIT_DRAIN;
        end else begin
          bus_req_o  = core_req_i && cnt_room;
          core_gnt_o = bus_gnt_i && cnt_room;
        end
      end
      WAIT_DRAIN: begin
        if (cnt_next == '0) begin
          state_d = ERR_RESP;
        end
      end
      ERR_RESP: begin
        core_rvalid_o  = 1'b1;
        core_err_o     = 1'b1;
        core_pma_err_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_next;
    end
  end

`ifdef CV32E40S_PMA_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Clear has priority over a coincident increment; the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (pma_err_cnt_clr_i) begin
      err_cnt_q <= '0;
    end else if ((state_q == ERR_RESP) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pma_err_cnt_o = err_cnt_q;
`else
  logic unused_err_cnt_clr;

  assign unused_err_cnt_clr = pma_err_cnt_clr_i;
  assign pma_err_cnt_o      = '0;
`endif

  // A bus response with nothing outstanding is a bus protocol violation.
  a_no_rvalid_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus_rvalid_i && (cnt == '0))
  );

endmodule

// File: tb/tb_cv32e40s_pma_filter.sv
// Scoreboard bench for cv32e40s_pma_filter: three instances (no regions,
// instruction side, data side) with directed vectors and a response monitor.
module tb_cv32e40s_pma_filter;
  import cv32e40s_pkg::*;

  // Instruction side: region 0 main [0x8000,0x9000), region 1 I/O [0x0,0x10000).
  localparam pma_cfg_t R_I0 = '{word_addr_low: 32'h2000, word_addr_high: 32'h2400,
                                main: 1'b1, bufferable: 1'b0, cacheable: 1'b1};
  localparam pma_cfg_t R_I1 = '{word_addr_low: 32'h0, word_addr_high: 32'h4000,
                                main: 1'b0, bufferable: 1'b0, cacheable: 1'b0};
  localparam pma_cfg_t CFG_I [1:0] = '{R_I1, R_I0};
  // Data side: region 0 I/O [0x0,0x1000), region 1 main [0x8000_0000,0x9000_0000).
  localparam pma_cfg_t R_D0 = '{word_addr_low: 32'h0, word_addr_high: 32'h400,
                                main: 1'b0, bufferable: 1'b1, cacheable: 1'b0};
  localparam pma_cfg_t R_D1 = '{word_addr_low: 32'h2000_0000, word_addr_high: 32'h2400_0000,
                                main: 1'b1, bufferable: 1'b1, cacheable: 1'b1};
  localparam pma_cfg_t CFG_D [1:0] = '{R_D1, R_D0};

`ifdef CV32E40S_PMA_ERR_CNT_EN
  localparam logic [15:0] EXP_CNT3 = 16'd3;
`else
  localparam logic [15:0] EXP_CNT3 = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req [3], we [3], mis [3], bgnt [3], brv [3], berr [3], clr [3];
  logic [31:0] addr [3];
  logic        gnt [3], rv [3], err [3], perr [3], breq [3], bwe [3], bbuf [3], bcac [3];
  logic [31:0] baddr [3];
  logic [15:0] ecnt [3];

  cv32e40s_pma_filter #(
    .PMA_NUM_REGIONS (0), .IS_INSTR_SIDE (1'b0), .MAX_OUTSTANDING (2)
  ) u_dut_n (
    .clk (clk), .rst_n (rst_n), .core_req_i (req[0]), .core_gnt_o (gnt[0]),
    .core_addr_i (addr[0]), .core_we_i (we[0]), .core_misaligned_i (mis[0]),
    .core_rvalid_o (rv[0]), .core_err_o (err[0]), .core_pma_err_o (perr[0]),
    .bus_req_o (breq[0]), .bus_gnt_i (bgnt[0]), .bus_addr_o (baddr[0]), .bus_we_o (bwe[0]),
    .bus_bufferable_o (bbuf[0]), .bus_cacheable_o (bcac[0]), .bus_rvalid_i (brv[0]),
    .bus_err_i (berr[0]), .pma_err_cnt_o (ecnt[0]), .pma_err_cnt_clr_i (clr[0])
  );

  cv32e40s_pma_filter #(
    .PMA_NUM_REGIONS (2), .PMA_CFG (CFG_I), .IS_INSTR_SIDE (1'b1), .MAX_OUTSTANDING (2)
  ) u_dut_i (
    .clk (clk), .rst_n (rst_n), .core_req_i (req[1]), .core_gnt_o (gnt[1]),
    .core_addr_i (addr[1]), .core_we_i (we[1]), .core_misaligned_i (mis[1]),
    .core_rvalid_o (rv[1]), .core_err_o (err[1]), .core_pma_err_o (perr[1]),
    .bus_req_o (breq[1]), .bus_gnt_i (bgnt[1]), .bus_addr_o (baddr[1]), .bus_we_o (bwe[1]),
    .bus_bufferable_o (bbuf[1]), .bus_cacheable_o (bcac[1]), .bus_rvalid_i (brv[1]),
    .bus_err_i (berr[1]), .pma_err_cnt_o (ecnt[1]), .pma_err_cnt_clr_i (clr[1])
  );

  cv32e40s_pma_filter #(
    .PMA_NUM_REGIONS (2), .PMA_CFG (CFG_D), .IS_INSTR_SIDE (1'b0), .MAX_OUTSTANDING (2)
  ) u_dut_d (
    .clk (clk), .rst_n (rst_n), .core_req_i (req[2]), .core_gnt_o (gnt[2]),
    .core_addr_i (addr[2]), .core_we_i (we[2]), .core_misaligned_i (mis[2]),
    .core_rvalid_o (rv[2]), .core_err_o (err[2]), .core_pma_err_o (perr[2]),
    .bus_req_o (breq[2]), .bus_gnt_i (bgnt[2]), .bus_addr_o (baddr[2]), .bus_we_o (bwe[2]),
    .bus_bufferable_o (bbuf[2]), .bus_cacheable_o (bcac[2]), .bus_rvalid_i (brv[2]),
    .bus_err_i (berr[2]), .pma_err_cnt_o (ecnt[2]), .pma_err_cnt_clr_i (clr[2])
  );

  typedef struct {
    int   id;
    logic err;
    logic pma;
  } rsp_t;

  rsp_t exp_q [$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input int id, input logic e, input logic p);
    exp_q.push_back('{id: id, err: e, pma: p});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; mis[k] = 1'b0; bgnt[k] = 1'b0;
      brv[k] = 1'b0; berr[k] = 1'b0; clr[k] = 1'b0; addr[k] = 32'h0;
    end
  endtask

  // Monitor: every core response pops the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rv[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: dut %0d err=%b pma_err=%b, no response expected (t=%0t)",
                   k, err[k], perr[k], $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_dut_id", k, mon_e.id);
          check("rsp_err", err[k], mon_e.err);
          check("rsp_pma_err", perr[k], mon_e.pma);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    addr[2] = 32'h1234_5678;
    we[2]   = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    // Reset values
    check("rst_bus_req", breq[2], 1'b0);
    check("rst_core_gnt", gnt[2], 1'b0);
    check("rst_core_rvalid", rv[2], 1'b0);
    check("rst_core_err", err[2], 1'b0);
    check("rst_pma_err", perr[2], 1'b0);
    check("rst_cnt", u_dut_d.cnt, 0);
    check("rst_err_cnt", ecnt[2], 16'h0);
    check("rst_bus_addr_follows", baddr[2], 32'h1234_5678);
    check("rst_bus_we_follows", bwe[2], 1'b1);
    clear_inputs();
    rst_n = 1'b1;

    // No regions: store passes through with default attributes
    step();
    req[0] = 1'b1; addr[0] = 32'h8000_0000; we[0] = 1'b1; bgnt[0] = 1'b1;
    #2;
    check("nopma_bus_req", breq[0], 1'b1);
    check("nopma_core_gnt", gnt[0], 1'b1);
    check("nopma_bufferable", bbuf[0], 1'b0);
    check("nopma_cacheable", bcac[0], 1'b0);
    check("nopma_bus_addr", baddr[0], 32'h8000_0000);
    expect_rsp(0, 1'b0, 1'b0);
    step();
    req[0] = 1'b0; we[0] = 1'b0; bgnt[0] = 1'b0; brv[0] = 1'b1;
    #2;
    check("nopma_cnt_one", u_dut_n.cnt, 1);
    check("nopma_rvalid_passthru", rv[0], 1'b1);
    step();
    brv[0] = 1'b0;
    #2;
    check("nopma_cnt_zero", u_dut_n.cnt, 0);

    // Instruction side: fetch from I/O region is blocked, error at T+1
    step();
    req[1] = 1'b1; addr[1] = 32'h40;
    #2;
    check("ifetch_io_bus_req", breq[1], 1'b0);
    check("ifetch_io_gnt", gnt[1], 1'b1);
    check("ifetch_io_no_early_rsp", rv[1], 1'b0);
    expect_rsp(1, 1'b1, 1'b1);
    step();
    req[1] = 1'b0;
    #2;
    check("ifetch_err_rvalid", rv[1], 1'b1);
    check("ifetch_err_pma", perr[1], 1'b1);
    check("ifetch_err_no_gnt", gnt[1], 1'b0);
    step();
    #2;
    check("ifetch_err_one_cycle", rv[1], 1'b0);

    // Overlap: lowest index (main) wins
    step();
    req[1] = 1'b1; addr[1] = 32'h8040; bgnt[1] = 1'b1;
    #2;
    check("overlap_bus_req", breq[1], 1'b1);
    check("overlap_gnt", gnt[1], 1'b1);
    check("overlap_cacheable", bcac[1], 1'b1);
    expect_rsp(1, 1'b0, 1'b0);
    step();
    req[1] = 1'b0; bgnt[1] = 1'b0; brv[1] = 1'b1;
    #2;
    check("overlap_rvalid", rv[1], 1'b1);
    step();
    brv[1] = 1'b0; req[1] = 1'b1; addr[1] = 32'h8FFC;
    #2;
    check("last_word_in_region_req", breq[1], 1'b1);
    check("last_word_no_gnt", gnt[1], 1'b0);
    step();
    addr[1] = 32'h9000;
    #2;
    check("high_exclusive_blocked", breq[1], 1'b0);
    check("high_exclusive_gnt", gnt[1], 1'b1);
    expect_rsp(1, 1'b1, 1'b1);
    step();
    req[1] = 1'b0;
    step();
    req[1] = 1'b1; addr[1] = 32'h2_0000;
    #2;
    check("no_match_blocked", breq[1], 1'b0);
    expect_rsp(1, 1'b1, 1'b1);
    step();
    req[1] = 1'b0;
    step();
    #2;
    check("err_cnt_three", ecnt[1], EXP_CNT3);

    // Clear coinciding with an error response
    step();
    req[1] = 1'b1; addr[1] = 32'h40;
    expect_rsp(1, 1'b1, 1'b1);
    step();
    req[1] = 1'b0; clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    #2;
    check("err_cnt_clear_wins", ecnt[1], 16'h0);

`ifdef CV32E40S_PMA_ERR_CNT_EN
    // Saturation at 0xFFFF
    step();
    force u_dut_i.err_cnt_q = 16'hFFFF;
    #1;
    release u_dut_i.err_cnt_q;
    req[1] = 1'b1; addr[1] = 32'h40;
    expect_rsp(1, 1'b1, 1'b1);
    step();
    req[1] = 1'b0;
    step();
    #2;
    check("err_cnt_saturates", ecnt[1], 16'hFFFF);
`endif

    // Data side: two loads, then a blocked misaligned access waits for drain
    step();
    req[2] = 1'b1; addr[2] = 32'h8000_0000; bgnt[2] = 1'b1;
    #2;
    check("load_bus_req", breq[2], 1'b1);
    check("load_cacheable", bcac[2], 1'b1);
    check("load_not_bufferable", bbuf[2], 1'b0);
    expect_rsp(2, 1'b0, 1'b0);
    step();
    #2;
    check("load2_gnt", gnt[2], 1'b1);
    expect_rsp(2, 1'b0, 1'b0);
    step();
    addr[2] = 32'h40; mis[2] = 1'b1;
    #2;
    check("mis_io_bus_req", breq[2], 1'b0);
    check("mis_io_gnt", gnt[2], 1'b1);
    check("mis_io_cnt_two", u_dut_d.cnt, 2);
    expect_rsp(2, 1'b1, 1'b1);
    step();
    req[2] = 1'b0; mis[2] = 1'b0; brv[2] = 1'b1;
    #2;
    check("drain_no_gnt", gnt[2], 1'b0);
    check("drain_first_pma", perr[2], 1'b0);
    step();
    #2;
    check("drain_second_pma", perr[2], 1'b0);
    step();
    brv[2] = 1'b0; bgnt[2] = 1'b0;
    #2;
    check("drain_err_rvalid", rv[2], 1'b1);
    check("drain_err_pma", perr[2], 1'b1);
    step();
    #2;
    check("drain_err_done", rv[2], 1'b0);

    // Attribute combinations without bus transfers
    req[2] = 1'b1; addr[2] = 32'h8000_0000; we[2] = 1'b1;
    #1;
    check("store_bufferable", bbuf[2], 1'b1);
    addr[2] = 32'h40; we[2] = 1'b0;
    #1;
    check("aligned_io_permitted", breq[2], 1'b1);
    check("io_not_cacheable", bcac[2], 1'b0);
    req[2] = 1'b0;

    // Full outstanding window stalls the core; bus error passes through
    step();
    req[2] = 1'b1; addr[2] = 32'h8000_0000; bgnt[2] = 1'b1;
    expect_rsp(2, 1'b1, 1'b0);
    step();
    expect_rsp(2, 1'b0, 1'b0);
    step();
    #2;
    check("full_no_gnt", gnt[2], 1'b0);
    check("full_no_bus_req", breq[2], 1'b0);
    step();
    brv[2] = 1'b1; berr[2] = 1'b1;
    #2;
    check("full_rsp_no_gnt", gnt[2], 1'b0);
    check("bus_err_passthru", err[2], 1'b1);
    check("bus_err_not_pma", perr[2], 1'b0);
    step();
    brv[2] = 1'b0; berr[2] = 1'b0;
    #2;
    check("room_gnt", gnt[2], 1'b1);
    check("room_bus_req", breq[2], 1'b1);
    expect_rsp(2, 1'b0, 1'b0);
    step();
    req[2] = 1'b0; bgnt[2] = 1'b0; brv[2] = 1'b1;
    step();
    step();
    brv[2] = 1'b0;
    #2;
    check("full_cnt_zero", u_dut_d.cnt, 0);

    // Reset during WAIT_DRAIN drops the pending error response
    step();
    req[2] = 1'b1; addr[2] = 32'h8000_0000; bgnt[2] = 1'b1;
    step();
    addr[2] = 32'h40; mis[2] = 1'b1;
    #2;
    check("rst_drain_blocked_gnt", gnt[2], 1'b1);
    step();
    req[2] = 1'b0; mis[2] = 1'b0; bgnt[2] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cnt", u_dut_d.cnt, 0);
    check("rst_mid_state", u_dut_d.state_q, IDLE);
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_mid_no_rsp", rv[2], 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
